// File: rtl/lsu_axi_master.sv
// ============================================================================
// Module  : lsu_axi_master
// Brief   : LSU-side data-bus initiator; one load/store at a time, with store
//           alignment, load extraction and misalignment/timeout errors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_axi_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_SEND = 3'd3,
    S_WR_WAIT = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam int c_cnt_w = $clog2(TIMEOUT + 1) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  state_t              r_state, w_next;
  logic [2:0]          r_off;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_aw_done, r_w_done;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;
  logic [ADDR_W-1:0]   r_araddr, r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_wstrb;
  logic                r_resp_valid, r_resp_err;
  logic [DATA_W-1:0]   r_resp_rdata;

  logic                w_accept, w_misaligned, w_rd_done, w_wr_done, w_timeout;
  logic [7:0]          w_mask;
  logic [DATA_W-1:0]   w_shift, w_ld_data;
  logic                w_unused;

  // Write responses are signalled by the bresp pulse alone.
  assign w_unused = &{1'b0, bvalid};

  always_comb begin
    w_misaligned = 1'b0;
    w_mask       = 8'h01;
    case (req_size)
      2'd0: begin w_misaligned = 1'b0;             w_mask = 8'h01; end
      2'd1: begin w_misaligned = req_addr[0];      w_mask = 8'h03; end
      2'd2: begin w_misaligned = |req_addr[1:0];   w_mask = 8'h0F; end
      default: begin w_misaligned = |req_addr[2:0]; w_mask = 8'hFF; end
    endcase
  end

  always_comb begin
    w_shift   = rdata >> {r_off, 3'b000};
    w_ld_data = w_shift;
    case (r_size)
      2'd0: w_ld_data = {{(DATA_W-8){~r_unsigned & w_shift[7]}}, w_shift[7:0]};
      2'd1: w_ld_data = {{(DATA_W-16){~r_unsigned & w_shift[15]}}, w_shift[15:0]};
      2'd2: w_ld_data = {{(DATA_W-32){~r_unsigned & w_shift[31]}}, w_shift[31:0]};
      default: w_ld_data = w_shift;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_rd_done = 1'b0;
    w_wr_done = 1'b0;
    w_timeout = 1'b0;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_misaligned)   w_next = S_RESP;
          else if (req_write) w_next = S_WR_SEND;
          else                w_next = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rready = 1'b1;
        // A completion in the final waiting cycle takes priority over timeout.
        if (rvalid && rresp) begin
          w_rd_done = 1'b1;
          w_next    = S_RESP;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_WR_SEND: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_next = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        bready = 1'b1;
        if (bresp) begin
          w_wr_done = 1'b1;
          w_next    = S_RESP;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_off        <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_araddr     <= '0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_off      <= req_addr[2:0];
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        r_data     <= '0;
        r_err      <= w_misaligned;
        if (!w_misaligned) begin
          if (req_write) begin
            r_awaddr <= {req_addr[ADDR_W-1:3], 3'b000};
            r_wdata  <= req_wdata << {req_addr[2:0], 3'b000};
            r_wstrb  <= w_mask << req_addr[2:0];
          end else begin
            r_araddr <= {req_addr[ADDR_W-1:3], 3'b000};
          end
        end
      end
      if (awvalid && awready) r_aw_done <= 1'b1;
      if (wvalid && wready)   r_w_done  <= 1'b1;

      if (r_state == S_RD_WAIT || r_state == S_WR_WAIT) r_cnt <= r_cnt + 1'b1;
      else                                              r_cnt <= '0;

      if (w_rd_done) begin
        r_data <= w_ld_data;
        r_err  <= 1'b0;
      end else if (w_wr_done) begin
        r_err  <= 1'b0;
      end else if (w_timeout) begin
        r_data <= '0;
        r_err  <= 1'b1;
      end

      // Response fields are forced to zero outside the pulse.
      r_resp_valid <= (r_state == S_RESP);
      r_resp_err   <= (r_state == S_RESP) ? r_err  : 1'b0;
      r_resp_rdata <= (r_state == S_RESP) ? r_data : '0;
    end
  end

  assign araddr     = r_araddr;
  assign awaddr     = r_awaddr;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

`default_nettype wire
